// File: rtl/tex_cache_pkg.sv
// rtl/tex_cache_pkg.sv - shared constants, bank encodings and FSM states for the texture cache fill path
package tex_cache_pkg;

  localparam int NUM_BANKS      = 4;
  localparam int LINE_WORDS_DEF = 8;
  localparam int IDX_W_DEF      = $clog2(LINE_WORDS_DEF);

  localparam logic [NUM_BANKS-1:0] CACHE_0 = 4'b0001;
  localparam logic [NUM_BANKS-1:0] CACHE_1 = 4'b0010;
  localparam logic [NUM_BANKS-1:0] CACHE_2 = 4'b0100;
  localparam logic [NUM_BANKS-1:0] CACHE_3 = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MEM_REQ,
    ST_FILL
  } fill_state_e;

  // Lowest set bit as one-hot; an empty vector maps to bank 0 so a victim always exists.
  function automatic logic [NUM_BANKS-1:0] lowest_onehot(input logic [NUM_BANKS-1:0] v);
    lowest_onehot = CACHE_0;
    for (int i = NUM_BANKS - 1; i >= 0; i--) begin
      if (v[i]) lowest_onehot = CACHE_0 << i;
    end
  endfunction

endpackage

// File: rtl/tex_tag_array.sv
// rtl/tex_tag_array.sv - four bank tags with valid bits, combinational hit vector, write/invalidate/flush
module tex_tag_array
  import tex_cache_pkg::*;
#(
  parameter int TAG_W = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [TAG_W-1:0]     lookup_tag,
  output logic [NUM_BANKS-1:0] hit_vec,
  output logic [NUM_BANKS-1:0] valid,
  input  logic                 inval_en,
  input  logic [NUM_BANKS-1:0] inval_bank,
  input  logic                 wr_en,
  input  logic [NUM_BANKS-1:0] wr_bank,
  input  logic [TAG_W-1:0]     wr_tag
);

  logic [NUM_BANKS-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q [NUM_BANKS];
  logic [TAG_W-1:0]     tag_d [NUM_BANKS];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    if (flush) begin
      valid_d = '0;
    end else begin
      if (inval_en) valid_d = valid_d & ~inval_bank;
      if (wr_en) begin
        valid_d = valid_d | wr_bank;
        for (int i = 0; i < NUM_BANKS; i++) begin
          if (wr_bank[i]) tag_d[i] = wr_tag;
        end
      end
    end
  end

  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      hit_vec[i] = valid_q[i] && (tag_q[i] == lookup_tag);
    end
  end

  assign valid = valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      tag_q   <= '{default: '0};
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
    end
  end

endmodule

// File: rtl/tex_cache_fill_ctrl.sv
// rtl/tex_cache_fill_ctrl.sv - texture cache front end: tag lookup, victim choice, line fill, LRU access pulses
module tex_cache_fill_ctrl
  import tex_cache_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int IDX_W      = $clog2(LINE_WORDS),
  parameter int TAG_W      = ADDR_W - IDX_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic                 flush,
  input  logic [NUM_BANKS-1:0] lru,
  output logic                 lru_read_en,
  output logic [NUM_BANKS-1:0] lru_bank_hit,
  output logic                 mem_req_valid,
  input  logic                 mem_req_ready,
  output logic [ADDR_W-1:0]    mem_req_addr,
  input  logic                 mem_rsp_valid,
  input  logic [DATA_W-1:0]    mem_rsp_data,
  output logic                 fill_we,
  output logic [NUM_BANKS-1:0] fill_bank,
  output logic [IDX_W-1:0]     fill_idx,
  output logic [DATA_W-1:0]    fill_data,
  output logic                 resp_valid,
  output logic [NUM_BANKS-1:0] resp_bank,
  output logic [IDX_W-1:0]     resp_idx,
  output logic                 resp_hit
);

  fill_state_e          state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [NUM_BANKS-1:0] victim_q, victim_d;
  logic [IDX_W-1:0]     cnt_q, cnt_d;
  logic                 resp_valid_q, resp_valid_d;
  logic                 resp_hit_q, resp_hit_d;
  logic [NUM_BANKS-1:0] resp_bank_q, resp_bank_d;
  logic [IDX_W-1:0]     resp_idx_q, resp_idx_d;

  logic [TAG_W-1:0]     cur_tag;
  logic [NUM_BANKS-1:0] hit_vec, valid, victim_sel;
  logic                 tag_flush, inval_en, wr_en, beat, last_beat;

  assign cur_tag   = addr_q[ADDR_W-1:IDX_W];
  assign req_ready = (state_q == ST_IDLE) && !flush;
  assign tag_flush = (state_q == ST_IDLE) && flush;
  assign beat      = (state_q == ST_FILL) && mem_rsp_valid;
  assign last_beat = beat && (cnt_q == IDX_W'(LINE_WORDS - 1));

  // Refilling an empty bank never costs a resident line, so invalid banks beat the LRU hint.
  assign victim_sel = (|(~valid)) ? lowest_onehot(~valid) : lowest_onehot(lru);

  tex_tag_array #(.TAG_W(TAG_W)) u_tags (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (tag_flush),
    .lookup_tag (cur_tag),
    .hit_vec    (hit_vec),
    .valid      (valid),
    .inval_en   (inval_en),
    .inval_bank (victim_sel),
    .wr_en      (wr_en),
    .wr_bank    (victim_q),
    .wr_tag     (cur_tag)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    victim_d     = victim_q;
    cnt_d        = cnt_q;
    resp_valid_d = 1'b0;
    resp_hit_d   = 1'b0;
    resp_bank_d  = '0;
    resp_idx_d   = '0;
    inval_en     = 1'b0;
    wr_en        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          addr_d  = req_addr;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (|hit_vec) begin
          resp_valid_d = 1'b1;
          resp_hit_d   = 1'b1;
          resp_bank_d  = hit_vec;
          resp_idx_d   = addr_q[IDX_W-1:0];
          state_d      = ST_IDLE;
        end else begin
          victim_d = victim_sel;
          inval_en = 1'b1;
          state_d  = ST_MEM_REQ;
        end
      end
      ST_MEM_REQ: begin
        if (mem_req_ready) begin
          cnt_d   = '0;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (beat) cnt_d = cnt_q + IDX_W'(1);
        if (last_beat) begin
          wr_en        = 1'b1;
          resp_valid_d = 1'b1;
          resp_bank_d  = victim_q;
          resp_idx_d   = addr_q[IDX_W-1:0];
          cnt_d        = '0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      victim_q     <= '0;
      cnt_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_bank_q  <= '0;
      resp_idx_q   <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      victim_q     <= victim_d;
      cnt_q        <= cnt_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_bank_q  <= resp_bank_d;
      resp_idx_q   <= resp_idx_d;
    end
  end

  assign mem_req_valid = (state_q == ST_MEM_REQ);
  assign mem_req_addr  = mem_req_valid ? {cur_tag, {IDX_W{1'b0}}} : '0;
  assign fill_we       = beat;
  assign fill_bank     = beat ? victim_q : '0;
  assign fill_idx      = beat ? cnt_q : '0;
  assign fill_data     = beat ? mem_rsp_data : '0;
  assign resp_valid    = resp_valid_q;
  assign resp_hit      = resp_hit_q;
  assign resp_bank     = resp_bank_q;
  assign resp_idx      = resp_idx_q;
  assign lru_read_en   = resp_valid_q;
  assign lru_bank_hit  = resp_bank_q;

endmodule

// File: tb/tb_tex_cache_fill_ctrl.sv
// tb/tb_tex_cache_fill_ctrl.sv - self-checking bench: directed vector table, reset/flush corners, randomized accesses vs cache model
module tb_tex_cache_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_addr;
  logic        flush;
  logic [3:0]  lru;
  logic        lru_read_en;
  logic [3:0]  lru_bank_hit;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [15:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        fill_we;
  logic [3:0]  fill_bank;
  logic [2:0]  fill_idx;
  logic [31:0] fill_data;
  logic        resp_valid;
  logic [3:0]  resp_bank;
  logic [2:0]  resp_idx;
  logic        resp_hit;

  tex_cache_fill_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .flush         (flush),
    .lru           (lru),
    .lru_read_en   (lru_read_en),
    .lru_bank_hit  (lru_bank_hit),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .fill_we       (fill_we),
    .fill_bank     (fill_bank),
    .fill_idx      (fill_idx),
    .fill_data     (fill_data),
    .resp_valid    (resp_valid),
    .resp_bank     (resp_bank),
    .resp_idx      (resp_idx),
    .resp_hit      (resp_hit)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          fl;
    logic [15:0] addr;
    logic [3:0]  lru;
    int          stall;
    bit          gaps;
    bit          hit;
    logic [3:0]  bank;
  } vec_t;

  vec_t        tbl[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  bit          m_valid [4];
  logic [12:0] m_tag   [4];

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [15:0] x);
    return {x ^ 16'h5A3C, x};
  endfunction

  task automatic add(input bit fl, input logic [15:0] a, input logic [3:0] l, input int st,
                     input bit g, input bit h, input logic [3:0] b);
    vec_t v;
    v.fl = fl; v.addr = a; v.lru = l; v.stall = st; v.gaps = g; v.hit = h; v.bank = b;
    tbl.push_back(v);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_valid[i] = 1'b0;
  endtask

  // Cache behaviour from the rules: tag match hits; else first empty bank, else lowest LRU bit, else bank 0.
  task automatic predict(input logic [15:0] a, input logic [3:0] l, output bit hit, output logic [3:0] bank);
    int v;
    hit  = 1'b0;
    bank = 4'b0000;
    v    = -1;
    for (int i = 0; i < 4; i++) begin
      if (m_valid[i] && m_tag[i] == a[15:3]) begin
        hit  = 1'b1;
        bank = 4'(1 << i);
      end
    end
    if (!hit) begin
      for (int i = 3; i >= 0; i--) if (!m_valid[i]) v = i;
      if (v < 0) begin
        v = 0;
        for (int i = 3; i >= 0; i--) if (l[i]) v = i;
      end
      bank = 4'(1 << v);
    end
  endtask

  task automatic do_flush(input logic [15:0] a);
    bit bad;
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_addr = a;
    #1 chk(req_ready == 1'b0, "flush_blocks_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    bad = mem_req_valid || resp_valid;
    @(negedge clk);
    bad = bad || mem_req_valid || resp_valid;
    chk(!bad, "flush_request_not_accepted", 32'(bad), 32'd0);
    model_clear();
  endtask

  task automatic access(input logic [15:0] a, input logic [3:0] l, input int stall, input bit gaps,
                        input bit exp_hit, input logic [3:0] exp_bank, input int abort_beat);
    logic [15:0] base, first_addr;
    int          beats_seen, beats_sent, stall_left, req_cycles, k;
    bit          in_fill, drove_fill, got_resp, aborted, bad_stray, bad_we, bad_stable, seen_req, bad;
    base = a & 16'hFFF8;
    beats_seen = 0; beats_sent = 0; stall_left = stall; req_cycles = 0;
    in_fill = 1'b0; drove_fill = 1'b0; got_resp = 1'b0; aborted = 1'b0;
    bad_stray = 1'b0; bad_we = 1'b0; bad_stable = 1'b0; seen_req = 1'b0;
    first_addr = 16'h0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; lru = l;
    #1 chk(req_ready == 1'b1, "req_ready_idle", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 1'b0; req_addr = 16'($urandom);
    for (k = 0; k < 400 && !got_resp && !aborted; k++) begin
      if (k > 0) @(negedge clk);
      if (resp_valid) begin
        got_resp = 1'b1;
        chk(resp_hit == exp_hit, "resp_hit", 32'(resp_hit), 32'(exp_hit));
        chk(resp_bank == exp_bank, "resp_bank", 32'(resp_bank), 32'(exp_bank));
        chk(resp_idx == a[2:0], "resp_idx", 32'(resp_idx), 32'(a[2:0]));
        chk(lru_read_en == 1'b1, "lru_read_en", 32'(lru_read_en), 32'd1);
        chk(lru_bank_hit == exp_bank, "lru_bank_hit", 32'(lru_bank_hit), 32'(exp_bank));
        chk(req_ready == 1'b1, "req_ready_at_resp", 32'(req_ready), 32'd1);
        if (exp_hit) chk(k == 1, "hit_latency", 32'(k), 32'd1);
        else chk(beats_seen == 8, "fill_beat_count", 32'(beats_seen), 32'd8);
        chk(req_cycles == (exp_hit ? 0 : stall + 1), "mem_req_cycles", 32'(req_cycles), 32'(exp_hit ? 0 : stall + 1));
        if (seen_req) chk(first_addr == base, "mem_req_addr", 32'(first_addr), 32'(base));
        chk(!bad_stable, "mem_req_addr_stable", 32'(bad_stable), 32'd0);
        chk(!bad_stray, "no_early_pulse", 32'(bad_stray), 32'd0);
        chk(!bad_we, "fill_we_only_on_fill_beats", 32'(bad_we), 32'd0);
      end else if (lru_read_en || lru_bank_hit != 4'b0) begin
        bad_stray = 1'b1;
      end
      if (mem_req_valid) begin
        if (!seen_req) first_addr = mem_req_addr;
        seen_req = 1'b1;
        if (mem_req_addr !== first_addr) bad_stable = 1'b1;
        req_cycles++;
      end
      if (!got_resp && in_fill && abort_beat >= 0 && beats_sent == abort_beat) begin
        mem_rsp_valid = 1'b1; mem_rsp_data = word_of(base + 16'(beats_sent));
        rst_n = 1'b0;
        #1 chk(req_ready && !resp_valid && !mem_req_valid && !fill_we && !lru_read_en,
               "reset_mid_fill_outputs",
               32'({req_ready, resp_valid, mem_req_valid, fill_we, lru_read_en}), 32'b10000);
        @(negedge clk);
        rst_n = 1'b1;
        #1 bad = fill_we;
        @(negedge clk);
        #1 bad = bad || fill_we;
        chk(!bad, "beats_after_reset_ignored", 32'(bad), 32'd0);
        chk(beats_seen == abort_beat, "beats_before_reset", 32'(beats_seen), 32'(abort_beat));
        mem_rsp_valid = 1'b0;
        model_clear();
        aborted = 1'b1;
      end else if (!got_resp) begin
        drove_fill = 1'b0;
        mem_rsp_valid = 1'b0;
        if (in_fill && beats_sent < 8 && (!gaps || $urandom_range(0, 2) != 0)) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = word_of(base + 16'(beats_sent));
          beats_sent++;
          drove_fill = 1'b1;
        end else if (!in_fill && gaps) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = 32'hDEAD_BEEF;
        end
        if (mem_req_valid) begin
          if (stall_left > 0) begin
            mem_req_ready = 1'b0;
            stall_left--;
          end else begin
            mem_req_ready = 1'b1;
            in_fill = 1'b1;
          end
        end else begin
          mem_req_ready = 1'b0;
        end
        #1;
        if (fill_we !== drove_fill) bad_we = 1'b1;
        if (fill_we && drove_fill) begin
          chk(fill_bank == exp_bank, "fill_bank", 32'(fill_bank), 32'(exp_bank));
          chk(32'(fill_idx) == 32'(beats_seen), "fill_idx", 32'(fill_idx), 32'(beats_seen));
          chk(fill_data == word_of(base + 16'(beats_seen)), "fill_data", fill_data, word_of(base + 16'(beats_seen)));
          beats_seen++;
        end
      end
    end
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b0;
    if (!got_resp && !aborted) chk(1'b0, "response_timeout", 32'(k), 32'd0);
    if (got_resp) begin
      @(negedge clk);
      chk(!resp_valid && !lru_read_en && lru_bank_hit == 4'b0, "pulse_single_cycle",
          32'({resp_valid, lru_read_en, lru_bank_hit}), 32'd0);
      if (!exp_hit) begin
        for (int i = 0; i < 4; i++) begin
          if (exp_bank[i]) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = a[15:3];
          end
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    bit          h;
    logic [3:0]  b;
    logic [15:0] ra;
    logic [3:0]  rl;
    rst_n = 1'b0; req_valid = 1'b0; req_addr = 16'h0; flush = 1'b0; lru = 4'b0001;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
    model_clear();
    repeat (3) @(negedge clk);
    chk(req_ready == 1'b1, "reset_req_ready", 32'(req_ready), 32'd1);
    chk({resp_valid, resp_hit, resp_bank, resp_idx} == 9'b0, "reset_resp_outputs",
        32'({resp_valid, resp_hit, resp_bank, resp_idx}), 32'd0);
    chk({mem_req_valid, mem_req_addr, lru_read_en, lru_bank_hit} == 22'b0, "reset_mem_lru_outputs",
        32'({mem_req_valid, mem_req_addr, lru_read_en, lru_bank_hit}), 32'd0);
    chk({fill_we, fill_bank, fill_idx, fill_data} == 40'b0, "reset_fill_outputs", 32'(fill_we), 32'd0);
    rst_n = 1'b1;

    add(1'b0, 16'h0123, 4'b0001, 0, 1'b0, 1'b0, 4'b0001);
    add(1'b0, 16'h0125, 4'b0001, 0, 1'b0, 1'b1, 4'b0001);
    add(1'b1, 16'h0125, 4'b0001, 0, 1'b0, 1'b0, 4'b0001);
    add(1'b1, 16'h0000, 4'b0001, 0, 1'b0, 1'b0, 4'b0001);
    add(1'b0, 16'h0008, 4'b0001, 5, 1'b0, 1'b0, 4'b0010);
    add(1'b0, 16'h0010, 4'b0001, 0, 1'b1, 1'b0, 4'b0100);
    add(1'b0, 16'h0018, 4'b0001, 0, 1'b0, 1'b0, 4'b1000);
    add(1'b0, 16'h0020, 4'b0100, 0, 1'b0, 1'b0, 4'b0100);
    add(1'b0, 16'h0010, 4'b1000, 2, 1'b1, 1'b0, 4'b1000);
    add(1'b0, 16'h0003, 4'b0010, 0, 1'b1, 1'b1, 4'b0001);
    add(1'b0, 16'h0021, 4'b0001, 0, 1'b0, 1'b1, 4'b0100);
    add(1'b0, 16'h0017, 4'b0001, 0, 1'b0, 1'b1, 4'b1000);
    add(1'b0, 16'h001F, 4'b0000, 0, 1'b0, 1'b0, 4'b0001);
    add(1'b0, 16'h0002, 4'b0110, 1, 1'b1, 1'b0, 4'b0010);
    foreach (tbl[i]) begin
      if (tbl[i].fl) do_flush(tbl[i].addr);
      access(tbl[i].addr, tbl[i].lru, tbl[i].stall, tbl[i].gaps, tbl[i].hit, tbl[i].bank, -1);
    end

    access(16'h0044, 4'b0001, 0, 1'b0, 1'b0, 4'b0001, 4);
    access(16'h0044, 4'b0001, 0, 1'b1, 1'b0, 4'b0001, -1);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) do_flush(16'($urandom_range(0, 63)));
      ra = 16'($urandom_range(0, 63));
      rl = 4'($urandom);
      predict(ra, rl, h, b);
      access(ra, rl, $urandom_range(0, 3), 1'($urandom_range(0, 1)), h, b, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tex_cache_fill_ctrl.md
Name: tex_cache_fill_ctrl

Overview:
- Front end of the rasterizer's 4-bank texture cache; one line per bank.
- Accepts texel read requests and compares them against the four bank tags.
- On a miss, takes the victim from the LRU tracker's one-hot `lru` output, fetches the line from memory and writes it into the victim bank.
- Drives the LRU tracker's `read_en`/`bank_hit` inputs with one pulse per completed access.

Parameters:
- ADDR_W, 16, word address width
- DATA_W, 32, texel word width
- LINE_WORDS, 8, words per line; must be a power of 2, at least 2
- IDX_W, log2(LINE_WORDS), word-in-line index width; derived
- TAG_W, ADDR_W-IDX_W, tag width; derived

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when both high
- req_addr  in  ADDR_W  word address
- flush  in  1  invalidate all banks
- lru  in  4  one-hot least-recently-used bank from tracker
- lru_read_en  out  1  access pulse to tracker
- lru_bank_hit  out  4  one-hot bank touched by the access
- mem_req_valid  out  1  line fetch request
- mem_req_ready  in  1  memory accepts fetch
- mem_req_addr  out  ADDR_W  line-aligned address, low IDX_W bits zero
- mem_rsp_valid  in  1  fill beat valid
- mem_rsp_data  in  DATA_W  fill beat data, in order word 0..LINE_WORDS-1
- fill_we  out  1  bank RAM write strobe
- fill_bank  out  4  one-hot bank written
- fill_idx  out  IDX_W  word index written
- fill_data  out  DATA_W  word written
- resp_valid  out  1  access complete, data readable
- resp_bank  out  4  one-hot bank holding the word
- resp_idx  out  IDX_W  word index
- resp_hit  out  1  1 = hit, 0 = completed after fill

Behaviour:
- States: IDLE, LOOKUP, MEM_REQ, FILL.
- Reset (async): state IDLE; all valid bits 0; tags 0. All outputs 0 except req_ready=1.
- IDLE:
  - req_ready=1 unless flush=1.
  - flush=1 clears all valid bits that cycle and has priority over a simultaneous req_valid; the request is not accepted that cycle.
  - On accept, register req_addr and go to LOOKUP.
- LOOKUP (one cycle):
  - hit vector = valid[i] and tag[i]==addr[ADDR_W-1:IDX_W]. At most one bit is ever set.
  - Hit: next cycle pulse resp_valid=1, resp_hit=1, resp_bank=hit vector, resp_idx=addr[IDX_W-1:0], lru_read_en=1, lru_bank_hit=hit vector; go to IDLE.
  - Hit latency: accept edge t0, resp at t2; req_ready is high again at t2.
  - Miss: victim = lowest-index invalid bank if any, else `lru`. If `lru` is zero or not one-hot, victim = its lowest set bit, or bank 0 when zero.
  - On miss, clear valid[victim], latch victim, go to MEM_REQ.
- MEM_REQ:
  - mem_req_valid=1 with mem_req_addr = {tag, IDX_W'b0}, held stable until mem_req_ready.
  - Transfer occurs on the cycle both are high; then go to FILL with beat counter=0.
- FILL:
  - Each mem_rsp_valid beat drives fill_we=1, fill_bank=victim, fill_idx=counter, fill_data=mem_rsp_data, combinationally in the same cycle; counter increments.
  - On beat LINE_WORDS-1: tag[victim]=tag, valid[victim]=1. Next cycle pulse resp_valid=1, resp_hit=0, resp_bank=victim, resp_idx=addr idx, lru_read_en=1, lru_bank_hit=victim; go to IDLE.
  - Counter wraps to 0 only on a state exit.
- Ignored inputs:
  - mem_rsp_valid outside FILL is ignored.
  - flush outside IDLE is ignored; the caller holds it until req_ready.
- All pulses (resp_valid, lru_read_en) last exactly one cycle. lru_bank_hit=0 whenever lru_read_en=0.
- Reset mid-FILL abandons the line; the victim stays invalid. mem_rsp beats arriving after reset are ignored.
- One outstanding request; no hit-under-miss.

Decomposition:
- Shared package (tex_cache_pkg):
  - bank-count constant 4;
  - one-hot CACHE_0..CACHE_3 constants;
  - state encoding;
  - LINE_WORDS/IDX_W defaults.
- One sub-module, tex_tag_array: 4 tags plus valid bits, combinational hit vector, write and invalidate ports, flush clear.

Test Plan:
- After reset, request 0x0123 with lru=0001 → miss. Victim is bank 0 (invalid preferred). mem_req_addr=0x0120. 8 beats write fill_idx 0..7 to bank 0. Then resp_valid, resp_hit=0, resp_idx=3, lru_bank_hit=0001.
- Request 0x0125 after the previous fill → resp at t2 with resp_hit=1, resp_bank=0001, resp_idx=5, single lru_read_en pulse.
- Fill banks with lines 0x000, 0x008, 0x010, 0x018. Request 0x0020 with lru=0100 → victim bank 2, mem_req_addr=0x0020. Re-request 0x0010 → miss.
- Hold mem_req_ready low 5 cycles → mem_req_valid and mem_req_addr stable throughout. Insert gaps between mem_rsp_valid beats → fill_idx stays contiguous 0..7.
- In IDLE, assert flush together with req_valid → req_ready=0. Next access to a previously resident line misses.
- Deassert rst_n at FILL beat 4 → outputs clear immediately, req_ready=1. Re-request the same address → miss into the same bank with a full 8-beat fill.
